// File: rtl/addsub_checker.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_checker
//  Description : Response checker for the AddAndSub adder/subtractor.
//                Recomputes the golden result/flags for each accepted
//                vector, compares them with the DUT outputs and keeps
//                per-run pass/fail counts plus first-failure diagnostics.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] dut_result,
    input  logic             dut_overflow,
    input  logic             dut_carry,
    input  logic             dut_zero,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [3:0]       first_fail_mask
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_num_vec;
    logic [CNT_W-1:0] r_idx;

    // stage-1 register: mismatch vector of the most recently accepted input
    logic             r_s1_valid;
    logic [3:0]       r_s1_mask;
    logic [CNT_W-1:0] r_s1_idx;

    logic             w_start_acc;
    logic             w_accept;
    logic             w_last;

    // golden model
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_gold_res;
    logic             w_gold_c;
    logic             w_gold_of;
    logic             w_gold_z;
    logic [3:0]       w_mask;

    assign w_bx       = b ^ {WIDTH{cin}};
    assign w_sum      = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, cin};
    assign w_gold_res = w_sum[WIDTH-1:0];
    // raw carry-out: for subtract this is NOT borrow
    assign w_gold_c   = w_sum[WIDTH];
    assign w_gold_of  = (a[WIDTH-1] == w_bx[WIDTH-1]) && (w_gold_res[WIDTH-1] != a[WIDTH-1]);
    assign w_gold_z   = (w_gold_res == '0);

    // mask order: {result, overflow, carry, zero}
    assign w_mask = {(dut_result   != w_gold_res),
                     (dut_overflow != w_gold_of),
                     (dut_carry    != w_gold_c),
                     (dut_zero     != w_gold_z)};

    assign in_ready    = (r_state == RUN);
    assign busy        = (r_state == RUN) || (r_state == DRAIN);
    assign done        = (r_state == DONE);
    assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept    = in_valid && in_ready;
    assign w_last      = (r_idx == (r_num_vec - c_one));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic; start is honoured only in IDLE/DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = (num_vec != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (w_accept && w_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // run length latch and accepted-vector index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_vec <= '0;
            r_idx     <= '0;
        end else if (w_start_acc) begin
            r_num_vec <= num_vec;
            r_idx     <= '0;
        end else if (w_accept) begin
            r_idx     <= r_idx + c_one;
        end
    end

    // stage 1: capture the mismatch vector on the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mask  <= '0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_mask <= w_mask;
                r_s1_idx  <= r_idx;
            end
        end
    end

    // stage 2: commit counts and hold the first failure of the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_mask  <= '0;
        end else if (w_start_acc) begin
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_mask  <= '0;
        end else if (r_s1_valid) begin
            if (r_s1_mask == 4'b0000) begin
                pass_cnt <= pass_cnt + c_one;
            end else begin
                fail_cnt <= fail_cnt + c_one;
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= r_s1_idx;
                    first_fail_mask  <= r_s1_mask;
                end
            end
        end
    end

endmodule
`default_nettype wire
